bf_3in_resp_checker: RTL
========================

// Module: bf_3in_resp_checker
// PURPOSE
//   Response side of the 3-input boolean-function test setup: watches the
//   {inA,inB,inC} stimulus and the DUT output, samples each stable vector once
//   it has settled, and compares it with a truth table given as a parameter.
//   Accumulates mismatch count, 8-vector coverage and first failing vector;
//   asserts done/pass once all 8 input combinations have been checked.
//   Sits beside the bf_* function under test in on-board self-check builds.
// PARAMETERS
//   EXPECTED  8'b1110_1000  truth table; bit i = expected out for {inA,inB,inC}==i
//   SETTLE    4             stable cycles required before sampling (>=1)
//   CNT_W     4             width of mismatch counter (saturating)
// PORTS
//   clk               in   1      system clock, all logic on rising edge
//   rst               in   1      synchronous reset, active-high
//   start             in   1      1-cycle pulse: clear stats and begin a check run
//   inA,inB,inC       in   1 ea   stimulus applied to DUT; idx = {inA,inB,inC}
//   dut_out           in   1      DUT response
//   busy              out  1      run in progress (state != IDLE/DONE)
//   done              out  1      all 8 vectors sampled; held until start/rst
//   pass              out  1      valid when done: 1 iff mismatch_cnt == 0
//   mismatch_cnt      out  CNT_W  number of failing samples, saturates at all-1s
//   coverage          out  8      bit i set once vector i has been sampled
//   first_fail_idx    out  3      idx of the first failing sample
//   first_fail_valid  out  1      first_fail_idx holds a captured value
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, pass, mismatch_cnt, coverage,
//     first_fail_idx, first_fail_valid all 0. rst wins over every other input,
//     including mid-run; no partial results survive.
//   - FSM states: IDLE, SETTLE, SAMPLE, HOLD, DONE.
//   - IDLE/DONE + start: clear all stats, done=0, prev_idx<=idx, settle_cnt<=0,
//     -> SETTLE. start in SETTLE/SAMPLE/HOLD ignored.
//   - SETTLE: if idx != prev_idx: prev_idx<=idx, settle_cnt<=0 (restart).
//     Else settle_cnt++; when settle_cnt == SETTLE-1 -> SAMPLE. So sampling
//     occurs SETTLE cycles after the last idx change.
//   - SAMPLE (exactly 1 cycle): compare dut_out with EXPECTED[prev_idx].
//     Mismatch: mismatch_cnt++ (hold at max); if !first_fail_valid capture
//     first_fail_idx<=prev_idx, first_fail_valid<=1. Always coverage[prev_idx]<=1.
//     If coverage incl. this bit == 8'hFF -> DONE, else -> HOLD.
//     Stats visible the cycle after SAMPLE.
//   - HOLD: wait for idx != prev_idx; then prev_idx<=idx, settle_cnt<=0,
//     -> SETTLE. A vector is sampled once per stable interval only.
//   - Revisited vectors are re-checked: mismatches still counted, coverage
//     unchanged. A glitch shorter than SETTLE cycles is never sampled.
//   - DONE: done=1, pass=(mismatch_cnt==0), busy=0; stats frozen; idx changes
//     ignored until start or rst.
//   - busy=1 in SETTLE, SAMPLE, HOLD; pass=0 whenever done=0.
// TESTING
//   1 Majority DUT, vectors 0..7 each held 100 clk, start at t0 -> done=1,
//     pass=1, coverage=8'hFF, mismatch_cnt=0, first_fail_valid=0.
//   2 Same sweep, dut_out forced 0 at idx 5 and 6 -> done=1, pass=0,
//     mismatch_cnt=2, first_fail_idx=3'd5, first_fail_valid=1.
//   3 idx toggles 3->4->3 with 2-cycle dwell (SETTLE=4) before settling on 7
//     -> only idx 7 sampled: coverage=8'h80, busy=1.
//   4 Sweep 0..7 then re-sweep 0..3 with all outputs inverted -> done after
//     first sweep with pass=1; later changes ignored, mismatch_cnt stays 0.
//   5 rst pulsed after 4 vectors sampled -> next cycle all outputs 0, IDLE;
//     new start + full good sweep -> pass=1, coverage=8'hFF.
//   6 CNT_W=2, inverted DUT, sweep 0..7 -> mismatch_cnt=2'b11 (saturated),
//     first_fail_idx=3'd0, pass=0.

Source files
------------

// File: rtl/bf_3in_resp_checker.sv
// Response checker for a 3-input boolean function: samples each settled {inA,inB,inC}
// vector once, compares dut_out against EXPECTED and accumulates pass/fail statistics.
module bf_3in_resp_checker #(
   parameter logic [7:0] EXPECTED = 8'b1110_1000,
   parameter int         SETTLE   = 4,
   parameter int         CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             inA,
   input  logic             inB,
   input  logic             inC,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [7:0]       coverage,
   output logic [2:0]       first_fail_idx,
   output logic             first_fail_valid
);

   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      idx;
   logic [2:0]      prev_idx;
   logic [SC_W-1:0] settle_cnt;
   logic            idx_chg;
   logic            mismatch;
   logic [7:0]      cov_upd;

   assign idx      = {inA, inB, inC};
   assign idx_chg  = (idx != prev_idx);
   assign mismatch = (dut_out != EXPECTED[prev_idx]);
   assign cov_upd  = coverage | (8'b1 << prev_idx);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (!idx_chg && settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
         end
         S_SAMPLE: begin
            state_nxt = (cov_upd == 8'hFF) ? S_DONE : S_HOLD;
         end
         S_HOLD: begin
            if (idx_chg) state_nxt = S_SETTLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         prev_idx         <= '0;
         settle_cnt       <= '0;
         mismatch_cnt     <= '0;
         coverage         <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  prev_idx         <= idx;
                  settle_cnt       <= '0;
                  mismatch_cnt     <= '0;
                  coverage         <= '0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
               end
            end
            S_SETTLE: begin
               // any change of the stimulus restarts the settle window
               if (idx_chg) begin
                  prev_idx   <= idx;
                  settle_cnt <= '0;
               end else if (settle_cnt != SETTLE_LAST) begin
                  settle_cnt <= settle_cnt + SC_W'(1);
               end
            end
            S_SAMPLE: begin
               if (mismatch) begin
                  if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                  if (!first_fail_valid) begin
                     first_fail_idx   <= prev_idx;
                     first_fail_valid <= 1'b1;
                  end
               end
               coverage <= cov_upd;
            end
            S_HOLD: begin
               if (idx_chg) begin
                  prev_idx   <= idx;
                  settle_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == S_SETTLE) || (state == S_SAMPLE) || (state == S_HOLD);
   assign done = (state == S_DONE);
   assign pass = done && (mismatch_cnt == '0);

endmodule
